serp_chain_model: RTL and testbench
===================================

# serp_chain_model

Cycle-level transport model of a parametrised chain of serpentine channel segments for the microfluidic flow. Each stage holds at most one fluid plug, a tagged sample word, for a programmable residence time that models the segment's transit delay. A plug then advances to the next stage when that stage can take it. The block sits between the inlet plug source and downstream mixer/detector models and replaces hand-chained fixed serpentine instances with one configurable, back-pressured, flushable chain.

## Interface
Parameters:
- N_STAGES, 4, number of serpentine segments in the chain (≥1)
- DATA_W, 8, plug tag/payload width
- CNT_W, 10, residence counter width
- DELAY_VEC, {10'd300,10'd300,10'd150,10'd50}, N_STAGES*CNT_W packed residence times in cycles, stage 0 in LSBs
- STAT_W, 16, delivered-plug counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  inlet plug present
- in_data  in  DATA_W  inlet plug tag
- in_ready  out  1  stage 0 can accept this cycle
- out_valid  out  1  last-stage plug has completed residence
- out_data  out  DATA_W  tag of that plug
- out_ready  in  1  downstream accepts
- flush  in  1  discard every plug in the chain (waste purge)
- occupancy  out  N_STAGES  bit i = stage i holds a plug
- delivered_cnt  out  STAT_W  plugs delivered at outlet, wraps modulo 2^STAT_W

## Operation
- Per-stage FSM states: EMPTY, DWELL, DONE.
- EMPTY→DWELL on load: latch the tag, counter := max(d_i,1), where d_i = DELAY_VEC[i]. A delay of 0 is clamped to 1.
- DWELL: counter decrements each edge. When counter reaches 0 → DONE.
- DONE→EMPTY when the plug leaves and no new plug loads. DONE→DWELL when it leaves and the upstream plug loads the same edge.
- Stage i (i<N_STAGES-1) leaves when it is DONE and stage i+1 can accept.
- Stage can accept = EMPTY, or DONE and leaving this cycle. The ready chain is combinational from out_ready back to in_ready.
- Last stage: out_valid = DONE. It leaves on out_valid && out_ready, which also increments delivered_cnt.
- in_ready = stage 0 can accept && !flush. A plug loads stage 0 on in_valid && in_ready.
- Plugs never overtake or merge; output order equals input order.
- flush: at the next edge all stages go to EMPTY, no transfer or load occurs, and delivered_cnt is unchanged. While flush is high, out_valid is forced 0 combinationally.

## Timing
- Reset values: all stages EMPTY, occupancy=0, out_valid=0, out_data=0, delivered_cnt=0. in_ready=1 once rst_n is high and flush is low.
- Reset mid-operation discards all plugs. It behaves identically to flush and also clears delivered_cnt.
- Unblocked latency: a plug accepted at edge t raises out_valid after edge t+Σmax(d_i,1). The default is 800 cycles.
- Throughput: one plug per max_i(max(d_i,1)) cycles in steady state. Full occupancy is N_STAGES plugs.
- Backpressure: with out_ready low, the last stage holds DONE, and upstream stages fill and park in DONE. in_ready falls once stage 0 is occupied and cannot leave.
- Simultaneous outlet and inlet on a full chain: a pass-through shift occurs in one edge, and occupancy stays all-ones.
- flush has priority over in_valid, out_ready and all internal transfers.
- out_data is held stable while out_valid && !out_ready.

## Structure
- Package serp_chain_pkg holds:
  - the stage-state enum (EMPTY/DWELL/DONE)
  - the default DELAY_VEC constants per segment length: 25px=25, 50px=50, 150px=150, 300px=300 cycles
  - a helper for clamping the delay.
- Sub-module serp_stage: one FSM, counter and tag register, with ports up_valid/up_ready/dn_valid/dn_ready plus flush. The top is a generate chain of N_STAGES instances, plus the outlet counter.

## Test plan
- Single plug: defaults, tag 0xA5 in at cycle 10, out_ready=1 → out_valid first high at cycle 810 with out_data=0xA5, delivered_cnt=1.
- Fill and stall: out_ready=0, offer 5 plugs 0x01..0x05 → occupancy=4'b1111, in_ready=0, 5th not accepted. Raise out_ready → outputs 0x01,0x02,0x03,0x04 in order.
- Flush: 3 plugs in flight, pulse flush with in_valid=1 → next cycle occupancy=0, in_data not loaded, delivered_cnt unchanged.
- Reset mid-operation: rst_n=0 for one edge with 2 plugs in flight → all outputs at reset values, delivered_cnt=0. A new plug then takes the full 800 cycles.
- Zero delay: DELAY_VEC={0,0,0,0}, N_STAGES=4 → latency 4 cycles, one plug per cycle throughput with out_ready=1.
- Counter wrap: STAT_W=4, deliver 17 plugs → delivered_cnt=1.

Source files
------------

// File: rtl/serp_chain_pkg.sv
// serp_chain_pkg: stage states, default segment residence times and delay clamp
// for the serpentine chain transport model.
package serp_chain_pkg;
   typedef enum logic [1:0] {EMPTY, DWELL, DONE} stage_state_e;
   localparam int SEG_25PX = 25;
   localparam int SEG_50PX = 50;
   localparam int SEG_150PX = 150;
   localparam int SEG_300PX = 300;
   localparam logic [39:0] DEF_DELAY_VEC = {10'(SEG_300PX), 10'(SEG_300PX), 10'(SEG_150PX), 10'(SEG_50PX)};
   function automatic int clamp_delay(input int d);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/serp_stage.sv
// serp_stage: one serpentine segment holding a single plug for its residence time;
// the plug is offered downstream in the last cycle of that residence.
module serp_stage
   import serp_chain_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W = 10,
   parameter int DELAY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   input  logic              dn_ready,
   output logic              occupied
);
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(clamp_delay(DELAY) - 1);
   stage_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic leave, load;
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state_q <= EMPTY;
         cnt_q <= '0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
      end
   end
   // cnt_q counts the cycles left before DONE, so a stage holds its plug exactly max(d,1) cycles
   always_comb begin
      load = up_valid && up_ready;
      state_d = load ? (LOAD_CNT == '0 ? DONE : DWELL)
              : leave ? EMPTY
              : (state_q == DWELL && cnt_q == CNT_W'(1)) ? DONE : state_q;
      cnt_d = load ? LOAD_CNT : (state_q == DWELL) ? cnt_q - CNT_W'(1) : cnt_q;
      data_d = load ? up_data : data_q;
   end
   always_comb begin
      dn_valid = state_q == DONE;
      leave = dn_valid && dn_ready;
      up_ready = state_q == EMPTY || leave;
      dn_data = data_q;
      occupied = state_q != EMPTY;
   end
endmodule

// File: rtl/serp_chain_model.sv
// serp_chain_model: back-pressured, flushable chain of serpentine stages with an
// outlet delivery counter.
module serp_chain_model
   import serp_chain_pkg::*;
#(
   parameter int N_STAGES = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W = 10,
   parameter logic [N_STAGES*CNT_W-1:0] DELAY_VEC = DEF_DELAY_VEC,
   parameter int STAT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                in_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   input  logic                out_ready,
   input  logic                flush,
   output logic [N_STAGES-1:0] occupancy,
   output logic [STAT_W-1:0]   delivered_cnt
);
   logic [STAT_W-1:0] delivered_q, delivered_d;
   for (genvar i = 0; i < N_STAGES; i++) begin : g
      logic uv, ur, dv, dr, occ;
      logic [DATA_W-1:0] ud, dd;
      if (i == 0) begin : h
         assign uv = in_valid;
         assign ud = in_data;
      end else begin : h
         assign uv = g[i-1].dv;
         assign ud = g[i-1].dd;
      end
      if (i == N_STAGES - 1) begin : t
         assign dr = out_ready && !flush;
      end else begin : t
         assign dr = g[i+1].ur;
      end
      serp_stage #(
         .DATA_W(DATA_W),
         .CNT_W(CNT_W),
         .DELAY(int'(DELAY_VEC[i*CNT_W +: CNT_W]))
      ) u_stage (
         .clk(clk),
         .rst_n(rst_n),
         .flush(flush),
         .up_valid(uv),
         .up_data(ud),
         .up_ready(ur),
         .dn_valid(dv),
         .dn_data(dd),
         .dn_ready(dr),
         .occupied(occ)
      );
      assign occupancy[i] = occ;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) delivered_q <= '0;
      else delivered_q <= delivered_d;
   end
   always_comb begin
      in_ready = g[0].ur && !flush;
      out_valid = g[N_STAGES-1].dv && !flush;
      out_data = g[N_STAGES-1].dd;
      delivered_d = delivered_q + STAT_W'(out_valid && out_ready);
      delivered_cnt = delivered_q;
   end
endmodule

// File: tb/tb_serp_chain_model.sv
// tb_serp_chain_model: scoreboard bench for the default chain and a zero-delay,
// 4-bit-counter chain.
module tb_serp_chain_model;
   typedef struct {
      logic [7:0] d;
      int c;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0;
   int errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic rst_n;
   logic a_iv, a_ir, a_ov, a_or, a_fl;
   logic [7:0] a_id, a_od;
   logic [3:0] a_occ;
   logic [15:0] a_dc;
   logic b_iv, b_ir, b_ov, b_or, b_fl;
   logic [7:0] b_id, b_od;
   logic [3:0] b_occ;
   logic [3:0] b_dc;
   bit acc;

   serp_chain_model dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
      .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .flush(a_fl),
      .occupancy(a_occ), .delivered_cnt(a_dc)
   );
   serp_chain_model #(.DELAY_VEC(40'd0), .STAT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
      .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .flush(b_fl),
      .occupancy(b_occ), .delivered_cnt(b_dc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic offer_a(input logic [7:0] d, input int budget, output bit ok);
      ok = 0;
      a_iv = 1'b1;
      a_id = d;
      for (int n = 0; n < budget && !ok; n++) begin
         if (a_ir) ok = 1;
         step(1);
      end
      a_iv = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      for (int n = 0; n < budget; n++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         step(1);
      end
      chk(name, qa.size() + qb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (a_ov && a_or) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_out: got unexpected data %0h at cycle %0d expected no output", a_od, cyc);
         end else begin
            ea = qa.pop_front();
            if (a_od !== ea.d || (ea.c >= 0 && cyc != ea.c)) begin
               errors++;
               $display("FAIL a_out: got data %0h at cycle %0d expected %0h at cycle %0d", a_od, cyc, ea.d, ea.c);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_ov && b_or) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_out: got unexpected data %0h at cycle %0d expected no output", b_od, cyc);
         end else begin
            eb = qb.pop_front();
            if (b_od !== eb.d || cyc != eb.c) begin
               errors++;
               $display("FAIL b_out: got data %0h at cycle %0d expected %0h at cycle %0d", b_od, cyc, eb.d, eb.c);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_iv = 1'b0; a_id = '0; a_or = 1'b1; a_fl = 1'b0;
      b_iv = 1'b0; b_id = '0; b_or = 1'b1; b_fl = 1'b0;
      step(3);
      chk("rst_occ", a_occ, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_od", a_od, 0);
      chk("rst_dc", a_dc, 0);
      rst_n = 1'b1;
      step(1);
      chk("rst_ir", a_ir, 1);
      // single plug: presented in cycle k, first visible at the outlet in cycle k+800
      qa.push_back('{8'hA5, cyc + 800});
      offer_a(8'hA5, 1, acc);
      chk("single_acc", acc, 1);
      drain("single_drain", 1000);
      chk("single_dc", a_dc, 1);
      // fill and stall
      a_or = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         offer_a(8'(j), 1000, acc);
         chk("fill_acc", acc, 1);
         qa.push_back('{8'(j), -1});
      end
      offer_a(8'h05, 600, acc);
      chk("fill_5th_rejected", acc, 0);
      chk("fill_occ", a_occ, 4'hF);
      chk("fill_ir", a_ir, 0);
      chk("fill_ov", a_ov, 1);
      a_or = 1'b1;
      drain("fill_drain", 2000);
      chk("fill_dc", a_dc, 5);
      // flush with three plugs in flight
      offer_a(8'h11, 1000, acc);
      offer_a(8'h22, 1000, acc);
      offer_a(8'h33, 1000, acc);
      chk("flush_pre_occ", a_occ != 0, 1);
      a_iv = 1'b1; a_id = 8'hEE; a_fl = 1'b1;
      #1;
      chk("flush_ir", a_ir, 0);
      chk("flush_ov", a_ov, 0);
      step(1);
      a_fl = 1'b0; a_iv = 1'b0;
      chk("flush_occ", a_occ, 0);
      chk("flush_dc", a_dc, 5);
      step(900);
      chk("flush_quiet_occ", a_occ, 0);
      // reset mid-operation
      offer_a(8'h44, 1000, acc);
      offer_a(8'h55, 1000, acc);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("midrst_occ", a_occ, 0);
      chk("midrst_ov", a_ov, 0);
      chk("midrst_od", a_od, 0);
      chk("midrst_dc", a_dc, 0);
      qa.push_back('{8'h3C, cyc + 800});
      offer_a(8'h3C, 1, acc);
      chk("midrst_acc", acc, 1);
      drain("midrst_drain", 1000);
      chk("midrst_dc_after", a_dc, 1);
      // zero-delay chain: latency 4, one plug per cycle, 4-bit counter wraps
      chk("b_rst_occ", b_occ, 0);
      chk("b_rst_dc", b_dc, 0);
      for (int j = 0; j < 17; j++) begin
         b_iv = 1'b1;
         b_id = 8'(j + 1);
         chk("b_ir", b_ir, 1);
         qb.push_back('{8'(j + 1), cyc + 4});
         step(1);
      end
      b_iv = 1'b0;
      drain("b_drain", 100);
      chk("b_wrap_dc", b_dc, 1);
      chk("b_occ_end", b_occ, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
